// File: rtl/ibus_fetcher_if.sv
// Pipelined instruction-bus interface between the fetch initiator (master) and the
// memory-side responder (slave); rddata_extra carries words 2 and 3 of wide blocks.
interface cpu_ibus_if;
  logic        read;
  logic [31:0] address;
  logic        flush_1;
  logic        flush_2;
  logic        stall;
  logic [63:0] rddata;
  logic [63:0] rddata_extra;

  modport master (
    output read, address, flush_1, flush_2,
    input  stall, rddata, rddata_extra
  );

  modport slave (
    input  read, address, flush_1, flush_2,
    output stall, rddata, rddata_extra
  );
endinterface

// File: rtl/ibus_fetcher.sv
// Instruction-fetch initiator: issues sequential block reads, tracks bus stages, and
// unpacks returned blocks into a PC-tagged FIFO. Define IBUS_FETCH_WIDE_EN for 16-byte blocks.
module ibus_fetcher #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] RESET_PC   = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  cpu_ibus_if.master  ibus,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

`ifdef IBUS_FETCH_WIDE_EN
  localparam int WORDS = 4;
`else
  localparam int WORDS = 2;
`endif
  localparam int          OFF_W     = $clog2(WORDS);
  localparam int          PTR_W     = $clog2(FIFO_DEPTH);
  localparam int          CNT_W     = PTR_W + 1;
  localparam logic [31:0] BLK_BYTES = 32'(WORDS * 4);
  localparam logic [31:0] BLK_MASK  = ~32'(WORDS * 4 - 1);

  logic [31:0]      pc_q, pc_d;
  logic             req_hold_q, req_hold_d;
  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_pc_q, s2_pc_d;
  logic             s3_valid_q, s3_valid_d;
  logic [31:0]      s3_pc_q, s3_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0] inst_mem_q [FIFO_DEPTH];
  logic [31:0] pc_mem_q   [FIFO_DEPTH];

  logic [31:0]      blk_word [WORDS];
  logic [OFF_W-1:0] s3_off;
  logic [WORDS-1:0] wr_en;
  logic [PTR_W-1:0] wr_idx [WORDS];
  logic [31:0]      wr_pc  [WORDS];
  logic [CNT_W-1:0] enq_cnt;

  int   free_slots;
  int   need_slots;
  logic credit_ok;
  logic read;
  logic flush;
  logic accept;
  logic deq;
  logic unused_ok;

  always_comb begin
    blk_word[0] = ibus.rddata[31:0];
    blk_word[1] = ibus.rddata[63:32];
`ifdef IBUS_FETCH_WIDE_EN
    blk_word[2] = ibus.rddata_extra[31:0];
    blk_word[3] = ibus.rddata_extra[63:32];
`endif
  end

`ifdef IBUS_FETCH_WIDE_EN
  assign unused_ok = ^redirect_pc[1:0];
`else
  assign unused_ok = ^{redirect_pc[1:0], ibus.rddata_extra};
`endif

  // Words below the tag's offset predate the fetch target and are skipped; the rest
  // are packed contiguously from the write pointer.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no latch is inferred.
    s3_off  = s3_pc_q[OFF_W+1:2];
    enq_cnt = '0;
    for (int k = 0; k < WORDS; k++) begin
      wr_en[k]  = s3_valid_q && (OFF_W'(k) >= s3_off);
      wr_idx[k] = wr_ptr_q + PTR_W'(k) - PTR_W'(s3_off);
      wr_pc[k]  = (s3_pc_q & BLK_MASK) + 32'(4 * k);
    end
    if (s3_valid_q) enq_cnt = CNT_W'(WORDS) - CNT_W'(s3_off);
  end

  always_comb begin
    free_slots = FIFO_DEPTH - int'(count_q);
    need_slots = WORDS * (int'(s2_valid_q) + int'(s3_valid_q) + 1);
    credit_ok  = free_slots >= need_slots;
    flush      = redirect_valid && !rst;
    // A request refused by stall stays asserted even if fetch_en drops meanwhile.
    read       = !rst && !redirect_valid && (req_hold_q || (fetch_en && credit_ok));
    accept     = read && !ibus.stall;
    deq        = inst_valid && inst_ready;

    pc_d       = pc_q;
    req_hold_d = 1'b0;
    s2_valid_d = s2_valid_q;
    s2_pc_d    = s2_pc_q;
    s3_valid_d = 1'b0;
    s3_pc_d    = s3_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      s2_valid_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      req_hold_d = read && ibus.stall;
      s3_valid_d = s2_valid_q && !ibus.stall;
      s3_pc_d    = s2_pc_q;
      if (accept) begin
        pc_d       = (pc_q & BLK_MASK) + BLK_BYTES;
        s2_valid_d = 1'b1;
        s2_pc_d    = pc_q;
      end else if (!ibus.stall) begin
        s2_valid_d = 1'b0;
      end
      wr_ptr_d = wr_ptr_q + PTR_W'(enq_cnt);
      rd_ptr_d = rd_ptr_q + PTR_W'(deq);
      count_d  = count_q + enq_cnt - CNT_W'(deq);
    end
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      req_hold_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s2_pc_q    <= '0;
      s3_valid_q <= 1'b0;
      s3_pc_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      req_hold_q <= req_hold_d;
      s2_valid_q <= s2_valid_d;
      s2_pc_q    <= s2_pc_d;
      s3_valid_q <= s3_valid_d;
      s3_pc_q    <= s3_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // NOTE: storage is not reset; count_q alone defines which entries are live.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS; k++) begin
      if (wr_en[k]) begin
        inst_mem_q[wr_idx[k]] <= blk_word[k];
        pc_mem_q[wr_idx[k]]   <= wr_pc[k];
      end
    end
  end

  assign ibus.read    = read;
  assign ibus.address = pc_q & BLK_MASK;
  assign ibus.flush_1 = flush;
  assign ibus.flush_2 = flush;

  assign inst_valid = (count_q != '0);
  assign inst       = inst_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign inst_pc    = inst_valid ? pc_mem_q[rd_ptr_q]   : '0;

endmodule

// File: tb/tb_ibus_fetcher.sv
// Bench for ibus_fetcher: a cycle-stepped responder plus a program-order model of the
// expected address and instruction streams, with directed scenarios and a random phase.
module tb_ibus_fetcher;
`ifdef IBUS_FETCH_WIDE_EN
  localparam int WORDS = 4;
  localparam int DEPTH = 16;
`else
  localparam int WORDS = 2;
  localparam int DEPTH = 8;
`endif
  localparam int          BLK      = WORDS * 4;
  localparam logic [31:0] BLK_MASK = ~32'(BLK - 1);
  localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        rst, fetch_en, redirect_valid, inst_ready, stall_drv;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst, inst_pc;

  cpu_ibus_if bus();
  // The responder drops stall whenever it sees a flush.
  assign bus.stall = stall_drv && !bus.flush_2;

  ibus_fetcher #(.FIFO_DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ibus(bus), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int ndeq  = 0;
  logic [31:0] exp_pc, exp_addr, prev_addr;
  logic        held, after_redirect, after_reset;
  logic        r_s2_v, r_d_v;
  logic [31:0] r_s2_a, r_d_a;
  logic        redir_had_valid, redir_had_data;
  int          log_from, vis_cyc;
  int          acc_cyc_q[$];
  logic [31:0] acc_addr_q[$];
  logic [31:0] deq_pc_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3c5a_96e1 ^ (a << 3);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic check_b(input string name, input logic got, input logic exp);
    check(name, {31'b0, got}, {31'b0, exp});
  endtask

  task automatic clear_logs(input int skip);
    log_from = cyc + skip;
    vis_cyc  = -1;
    acc_cyc_q.delete();
    acc_addr_q.delete();
    deq_pc_q.delete();
  endtask

  // One clock: drive at negedge, observe and check at negedge+1, advance responder at posedge.
  task automatic cycle(input logic rs, input logic fe, input logic rv, input logic [31:0] rpc,
                       input logic rdy, input logic st);
    logic        n_s2v, n_dv;
    logic [31:0] n_s2a, n_da;
    @(negedge clk);
    rst = rs; fetch_en = fe; redirect_valid = rv; redirect_pc = rpc;
    inst_ready = rdy; stall_drv = st;
    if (r_d_v) begin
      bus.rddata       = {word_at(r_d_a + 32'd4), word_at(r_d_a)};
      bus.rddata_extra = {word_at(r_d_a + 32'd12), word_at(r_d_a + 32'd8)};
    end else begin
      bus.rddata       = {$urandom, $urandom};
      bus.rddata_extra = {$urandom, $urandom};
    end
    #1;
    n_s2v = r_s2_v; n_s2a = r_s2_a; n_dv = 1'b0; n_da = r_d_a;
    if (rs) begin
      check_b("read_in_reset", bus.read, 1'b0);
      n_s2v = 1'b0; held = 1'b0; after_redirect = 1'b0; after_reset = 1'b1;
      exp_pc = RESET_PC; exp_addr = RESET_PC & BLK_MASK;
    end else begin
      if (after_reset) begin
        check_b("rst_inst_valid", inst_valid, 1'b0);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        after_reset = 1'b0;
      end
      if (after_redirect) check_b("empty_after_redirect", inst_valid, 1'b0);
      if (rv) begin
        redir_had_valid = inst_valid;
        redir_had_data  = r_d_v;
        check_b("redir_flush_1", bus.flush_1, 1'b1);
        check_b("redir_flush_2", bus.flush_2, 1'b1);
        check_b("redir_read", bus.read, 1'b0);
      end else begin
        check_b("flush_1_idle", bus.flush_1, 1'b0);
        check_b("flush_2_idle", bus.flush_2, 1'b0);
        if (held) begin
          check_b("hold_read", bus.read, 1'b1);
          check("hold_address", bus.address, prev_addr);
        end else if (!fe) begin
          check_b("idle_read", bus.read, 1'b0);
        end
        if (fe && !held && !r_s2_v && !r_d_v && !inst_valid) check_b("credit_read", bus.read, 1'b1);
      end
      if (inst_valid) begin
        if (cyc >= log_from && vis_cyc < 0) vis_cyc = cyc;
        if (rdy) begin
          check("inst_pc", inst_pc, exp_pc);
          check("inst", inst, word_at(exp_pc));
          exp_pc += 32'd4;
          ndeq++;
          if (cyc >= log_from) deq_pc_q.push_back(inst_pc);
        end
      end
      if (rv) begin
        exp_pc   = rpc & 32'hffff_fffc;
        exp_addr = rpc & BLK_MASK;
      end
      if (bus.read && !bus.stall) begin
        check("address", bus.address, exp_addr);
        exp_addr += 32'(BLK);
        if (cyc >= log_from) begin
          acc_addr_q.push_back(bus.address);
          acc_cyc_q.push_back(cyc);
        end
      end
      held           = bus.read && bus.stall;
      prev_addr      = bus.address;
      after_redirect = rv;
      if (rv) begin
        n_s2v = 1'b0;
      end else begin
        n_dv = r_s2_v && !bus.stall;
        n_da = r_s2_a;
        if (bus.read && !bus.stall) begin
          n_s2v = 1'b1;
          n_s2a = bus.address;
        end else if (!bus.stall) begin
          n_s2v = 1'b0;
        end
      end
    end
    @(posedge clk);
    r_s2_v = n_s2v; r_s2_a = n_s2a; r_d_v = n_dv; r_d_a = n_da;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; fetch_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    inst_ready = 1'b0; stall_drv = 1'b0;
    bus.rddata = '0; bus.rddata_extra = '0;
    r_s2_v = 1'b0; r_d_v = 1'b0; r_s2_a = '0; r_d_a = '0;
    held = 1'b0; after_redirect = 1'b0; after_reset = 1'b0;
    redir_had_valid = 1'b0; redir_had_data = 1'b0;
    exp_pc = RESET_PC; exp_addr = RESET_PC & BLK_MASK; prev_addr = '0;
    log_from = 0; vis_cyc = -1;

    // Reset, then stream with no stall: first request right after reset, data 3 cycles later.
    repeat (2) cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    clear_logs(0);
    repeat (12) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("lat_acc_count", 32'(acc_addr_q.size() >= 2), 32'd1);
    check("lat_deq_count", 32'(deq_pc_q.size() >= 2), 32'd1);
    if (acc_addr_q.size() >= 2 && deq_pc_q.size() >= 2) begin
      check("lat_first_req_cycle", 32'(acc_cyc_q[0] - log_from), 32'd0);
      check("lat_addr0", acc_addr_q[0], 32'hbfc0_0000);
      check("lat_addr1", acc_addr_q[1], 32'hbfc0_0000 + 32'(BLK));
      check("lat_pc0", deq_pc_q[0], 32'hbfc0_0000);
      check("lat_pc1", deq_pc_q[1], 32'hbfc0_0004);
      check("lat_first_valid", 32'(vis_cyc - acc_cyc_q[0]), 32'd3);
    end

    // Five stall cycles: nothing accepted, request held, stream stays contiguous after.
    clear_logs(0);
    repeat (5) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    check("stall_no_accept", 32'(acc_addr_q.size()), 32'd0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Credit limit: no dequeue for 20 cycles buffers exactly DEPTH instructions.
    clear_logs(1);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_2000, 1'b0, 1'b0);
    repeat (20) cycle(1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("credit_blocks", 32'(acc_addr_q.size()), 32'(DEPTH / WORDS));
    clear_logs(0);
    repeat (20) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1, 1'b0);
    check("credit_drained", 32'(deq_pc_q.size()), 32'(DEPTH));
    if (deq_pc_q.size() == DEPTH) begin
      check("credit_first_pc", deq_pc_q[0], 32'h0000_2000);
      check("credit_last_pc", deq_pc_q[DEPTH-1], 32'h0000_2000 + 32'(4 * (DEPTH - 1)));
    end

    // Redirect to a word-offset target while a request sits stalled in stage 2.
    repeat (6) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    clear_logs(1);
    cycle(1'b0, 1'b1, 1'b1, 32'h8000_1004, 1'b1, 1'b1);
    repeat (10) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    check("redir_acc_count", 32'(acc_addr_q.size() >= 1), 32'd1);
    check("redir_deq_count", 32'(deq_pc_q.size() >= 1), 32'd1);
    if (acc_addr_q.size() >= 1 && deq_pc_q.size() >= 1) begin
      check("redir_next_addr", acc_addr_q[0], 32'h8000_1000);
      check("redir_req_cycle", 32'(acc_cyc_q[0] - log_from), 32'd0);
      check("redir_first_pc", deq_pc_q[0], 32'h8000_1004);
      check("redir_visible_cycle", 32'(vis_cyc - log_from), 32'd3);
    end

    // Redirect in a cycle where a block is written and the head is consumed.
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 32'h0000_5000, 1'b1, 1'b0);
    check_b("coincide_head_valid", redir_had_valid, 1'b1);
    check_b("coincide_data_return", redir_had_data, 1'b1);
    repeat (6) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Reset in the middle of streaming.
    cycle(1'b1, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);

    // Random traffic, including targets just below the 32-bit wrap.
    ndeq = 0;
    for (int i = 0; i < 3000; i++) begin
      logic        rs, fe, rv, rdy, st;
      logic [31:0] rpc;
      rs  = ($urandom % 500) == 0;
      fe  = ($urandom % 10) != 0;
      rv  = ($urandom % 30) == 0;
      rpc = (($urandom % 4) == 0) ? (32'hffff_fff0 | ($urandom & 32'hf)) : $urandom;
      rdy = ($urandom % 10) < 7;
      st  = ($urandom % 5) == 0;
      cycle(rs, fe, rv, rpc, rdy, st);
    end
    check("random_progress", 32'(ndeq > 300), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
